// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with any depth >= 1, valid/ready on both sides,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
//
// Optional feature macro: SYNC_FIFO_PEAK_EN
//   defined   -> peak_count_o reports the highest occupancy since reset/flush
//   undefined -> no peak register, peak_count_o tied to 0
//
// Ports:
//   clk_i            clock, rising edge
//   arst_ni          asynchronous active-low reset
//   flush_i          synchronous clear of pointers/count/peak (memory untouched)
//   elem_in_i        input element
//   elem_in_valid_i  input valid
//   elem_in_ready_o  input ready (count < DEPTH and no flush)
//   elem_out_o       head element (first-word fall-through)
//   elem_out_valid_o output valid (count != 0 and no flush)
//   elem_out_ready_i output ready
//   count_o          current occupancy
//   almost_full_o    count >= AF_THRESH
//   almost_empty_o   count <= AE_THRESH
//   peak_count_o     highest occupancy since reset/flush
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Valid must not depend on ready. Ready on the input
// side ignores the output side, so a full FIFO never accepts a push even if
// a pop happens in the same cycle. flush_i masks both handshakes.

module sync_fifo #(
   parameter int ELEM_WIDTH = 8,
   parameter int DEPTH      = 6,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  flush_i,
   input  logic [ELEM_WIDTH-1:0] elem_in_i,
   input  logic                  elem_in_valid_i,
   output logic                  elem_in_ready_o,
   output logic [ELEM_WIDTH-1:0] elem_out_o,
   output logic                  elem_out_valid_o,
   input  logic                  elem_out_ready_i,
   output logic [CW-1:0]         count_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CW-1:0]         peak_count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [ELEM_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  hsi, hso;

   assign elem_in_ready_o  = (count_q < CW'(DEPTH)) & ~flush_i;
   assign elem_out_valid_o = (count_q != '0) & ~flush_i;
   assign hsi              = elem_in_valid_i & elem_in_ready_o;
   assign hso              = elem_out_valid_o & elem_out_ready_i;

   assign elem_out_o     = mem_q[rd_ptr_q];
   assign count_o        = count_q;
   assign almost_full_o  = count_q >= CW'(AF_THRESH);
   assign almost_empty_o = count_q <= CW'(AE_THRESH);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Explicit wrap so non-power-of-two depths work.
         if (hsi) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
         if (hso) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
         case ({hsi, hso})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (hsi) mem_q[wr_ptr_q] <= elem_in_i;
      end
   end

`ifdef SYNC_FIFO_PEAK_EN
   logic [CW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (flush_i)               peak_d = '0;
      else if (count_d > peak_q) peak_d = count_d;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) peak_q <= '0;
      else          peak_q <= peak_d;
   end

   assign peak_count_o = peak_q;
`else
   assign peak_count_o = '0;
`endif

endmodule
